// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the flash sequencing controller: command op codes,
// controller state encoding and requester identifiers.
package flash_ctrl_pkg;

    // Programming-port command codes
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_e;

    // Requester identifiers, also used as bit positions in the one-hot grant
    localparam logic WIN_IF = 1'b0;
    localparam logic WIN_PG = 1'b1;

endpackage

// File: rtl/flash_ctrl_arb.sv
// Fixed-priority arbiter between instruction fetch and programming, with a
// saturating fetch-streak counter so that programming cannot be starved by a
// continuously requesting fetch port.
module flash_ctrl_arb
    import flash_ctrl_pkg::*;
#(
    parameter int FETCH_BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic       pg_req,
    input  logic       idle,
    output logic [1:0] grant
);

    localparam int            CW      = $clog2(FETCH_BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FETCH_BURST_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          streak_full_s;

    assign streak_full_s = (cnt_q == CNT_MAX);

    // Grant decision: fetch first unless the fetch streak has used up its quota
    always_comb begin
        grant = 2'b00;
        if (idle) begin
            if (pg_req && (!if_req || streak_full_s)) begin
                grant[WIN_PG] = 1'b1;
            end else if (if_req) begin
                grant[WIN_IF] = 1'b1;
            end else begin
                grant = 2'b00;
            end
        end else begin
            grant = 2'b00;
        end
    end

    // Streak counter update: count fetch wins while programming waits
    always_comb begin
        cnt_d = cnt_q;
        if (idle) begin
            if (grant[WIN_PG] || !pg_req) begin
                cnt_d = {CW{1'b0}};
            end else if (grant[WIN_IF] && !streak_full_s) begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Streak counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flash_ctrl.sv
// Flash command sequencer: arbitrates fetch and programming requesters,
// rejects illegal accesses, issues one flash strobe at a time, respects the
// flash command timing and returns a one-cycle ack to the winner.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int AW              = 12,
    parameter int DW              = 32,
    parameter int DEPTH           = 1024,
    parameter int PROT_LIMIT      = 0,
    parameter int FETCH_BURST_MAX = 4,
    parameter int CMD_GAP         = 1
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          pg_req,
    input  logic [1:0]    pg_op,
    input  logic [AW-1:0] pg_addr,
    input  logic [DW-1:0] pg_wdata,
    input  logic          wp,
    output logic          pg_ack,
    output logic [DW-1:0] pg_rdata,
    output logic          pg_err,
    output logic          ctrl_busy,
    output logic          f_rd_en,
    output logic          f_wr_en,
    output logic          f_erase_en,
    output logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_idata,
    input  logic [DW-1:0] f_odata,
    input  logic          f_error
);

    // Last GAP count value; unused when the gap is disabled
    localparam logic [1:0] GAP_LAST = 2'(CMD_GAP - 1);

    state_e        state_q, state_d;
    logic [1:0]    gap_q, gap_d;
    logic          win_q, win_d;
    op_e           op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          if_err_q, if_err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          pg_ack_q, pg_ack_d;
    logic          pg_err_q, pg_err_d;
    logic [DW-1:0] pg_rdata_q, pg_rdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          er_q, er_d;
    logic          busy_q, busy_d;

    logic [1:0]    grant_s;
    logic          idle_s;
    logic          req_win_s;
    op_e           req_op_s;
    logic [AW-1:0] req_addr_s;
    logic          req_bad_s;

    // Legality check of a request; signed compares keep zero limits well-behaved
    function automatic logic check_bad(input op_e op, input logic [AW-1:0] addr, input logic wp_i);
        int   a_int;
        logic range_bad;
        logic op_bad;
        a_int     = int'(addr);
        range_bad = (a_int >= DEPTH);
        case (op)
            OP_READ:  op_bad = 1'b0;
            OP_WRITE: op_bad = wp_i || (a_int < PROT_LIMIT);
            OP_ERASE: op_bad = wp_i || (PROT_LIMIT != 0);
            OP_RSVD:  op_bad = 1'b1;
            default:  op_bad = 1'b1;
        endcase
        return range_bad || op_bad;
    endfunction

    assign idle_s = (state_q == IDLE);

    flash_ctrl_arb #(
        .FETCH_BURST_MAX (FETCH_BURST_MAX)
    ) u_arb (
        .clk    (clk),
        .rst    (RST),
        .if_req (if_req),
        .pg_req (pg_req),
        .idle   (idle_s),
        .grant  (grant_s)
    );

    // Select the winning requester's command fields and judge legality
    always_comb begin
        if (grant_s[WIN_PG]) begin
            req_win_s  = WIN_PG;
            req_addr_s = pg_addr;
            req_op_s   = op_e'(pg_op);
        end else begin
            req_win_s  = WIN_IF;
            req_addr_s = if_addr;
            req_op_s   = OP_READ;
        end
        req_bad_s = check_bad(req_op_s, req_addr_s, wp);
    end

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        win_d      = win_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_ack_d   = 1'b0;
        if_err_d   = if_err_q;
        if_rdata_d = if_rdata_q;
        pg_ack_d   = 1'b0;
        pg_err_d   = pg_err_q;
        pg_rdata_d = pg_rdata_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        er_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    win_d   = req_win_s;
                    op_d    = req_op_s;
                    addr_d  = req_addr_s;
                    wdata_d = pg_wdata;
                    if (req_bad_s) begin
                        // Rejected: ack next cycle, flash untouched
                        state_d = DONE;
                        if (req_win_s == WIN_PG) begin
                            pg_ack_d = 1'b1;
                            pg_err_d = 1'b1;
                        end else begin
                            if_ack_d = 1'b1;
                            if_err_d = 1'b1;
                        end
                    end else begin
                        state_d = ISSUE;
                        case (req_op_s)
                            OP_READ:  rd_d = 1'b1;
                            OP_WRITE: wr_d = 1'b1;
                            OP_ERASE: er_d = 1'b1;
                            default:  rd_d = 1'b0;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Flash response is valid now; ack lands in DONE
                state_d = DONE;
                if (win_q == WIN_PG) begin
                    pg_ack_d = 1'b1;
                    if (op_q == OP_WRITE) begin
                        pg_err_d = f_error;
                    end else begin
                        pg_err_d = 1'b0;
                    end
                    if (op_q == OP_READ) begin
                        pg_rdata_d = f_odata;
                    end else begin
                        pg_rdata_d = pg_rdata_q;
                    end
                end else begin
                    if_ack_d   = 1'b1;
                    if_err_d   = 1'b0;
                    if_rdata_d = f_odata;
                end
            end
            DONE: begin
                gap_d = 2'd0;
                if (CMD_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 2'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, latches and output registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            gap_q      <= 2'd0;
            win_q      <= WIN_IF;
            op_q       <= OP_READ;
            addr_q     <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= {DW{1'b0}};
            pg_ack_q   <= 1'b0;
            pg_err_q   <= 1'b0;
            pg_rdata_q <= {DW{1'b0}};
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            er_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            win_q      <= win_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            if_rdata_q <= if_rdata_d;
            pg_ack_q   <= pg_ack_d;
            pg_err_q   <= pg_err_d;
            pg_rdata_q <= pg_rdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            er_q       <= er_d;
            busy_q     <= busy_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_err     = if_err_q;
    assign if_rdata   = if_rdata_q;
    assign pg_ack     = pg_ack_q;
    assign pg_err     = pg_err_q;
    assign pg_rdata   = pg_rdata_q;
    assign ctrl_busy  = busy_q;
    assign f_rd_en    = rd_q;
    assign f_wr_en    = wr_q;
    assign f_erase_en = er_q;
    assign f_addr     = addr_q;
    assign f_idata    = wdata_q;

endmodule

// File: doc/flash_ctrl.md
Name: flash_ctrl

Overview:
Sequencing controller and arbiter in front of the on-chip flash array. It shares the single-command flash port between two requesters: a read-only instruction-fetch port and a programming port that can read, write or erase. It issues exactly one flash command at a time, observes the flash's fixed command timing, and reports completion with a one-cycle ack. It rejects out-of-range and write-protected accesses without touching the flash.

Parameters:
AW, 12, flash word-address width
DW, 32, data width
DEPTH, 1024, valid words; address >= DEPTH is an error
PROT_LIMIT, 0, words [0, PROT_LIMIT) are write-protected; a nonzero value also blocks erase
FETCH_BURST_MAX, 4, maximum consecutive fetch grants while pg_req is pending
CMD_GAP, 1, idle cycles forced after each flash command (0..3)

Ports:
clk  in  1  clock
RST  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch word address
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DW  fetch data, valid with if_ack and held until the next if_ack
if_err  out  1  valid with if_ack; set for out-of-range address
pg_req  in  1  programming request, held until pg_ack
pg_op  in  2  00 read, 01 write, 10 erase-all, 11 reserved
pg_addr  in  AW  word address
pg_wdata  in  DW  write data
wp  in  1  global write protect; blocks write and erase
pg_ack  out  1  one-cycle completion pulse
pg_rdata  out  DW  read data, valid with pg_ack
pg_err  out  1  valid with pg_ack
ctrl_busy  out  1  high in every state except IDLE
f_rd_en / f_wr_en / f_erase_en  out  1  flash command strobes, one-hot, each high for exactly one cycle
f_addr  out  AW  flash address
f_idata  out  DW  flash write data
f_odata  in  DW  flash read data
f_error  in  1  flash write-to-non-erased pulse

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the starvation counter is 0. Reset takes effect asynchronously; strobes drop immediately.
- Reset mid-command: no ack is issued. The flash has no reset, so its contents are whatever the last accepted strobe produced.
- Requesters hold req, addr, op and wdata stable until their ack. A req still high in the cycle after its ack is treated as a new request.
- States: IDLE -> ISSUE -> WAIT -> DONE -> GAP (CMD_GAP cycles; skipped when CMD_GAP is 0) -> IDLE. The reject path is IDLE -> DONE.
- IDLE (cycle C): arbitrate, latch the winner's addr, op and wdata, then check the request:
  - address >= DEPTH -> reject with err=1
  - pg_op=11 -> reject with err=1
  - write with wp=1 or addr < PROT_LIMIT -> reject with err=1
  - erase with wp=1 or PROT_LIMIT != 0 -> reject with err=1
  - A rejected request gets its ack in C+1 and issues no strobe.
- ISSUE (C+1): exactly one strobe is high; f_addr and f_idata are driven from the latches.
- WAIT (C+2): capture f_odata into the winner's rdata register for reads. For writes, capture f_error into err.
- DONE (C+3): the winner's ack=1 for one cycle. Erase and normal reads complete with err=0.
- Accepted-command latency is therefore ack at C+3. The next strobe comes no earlier than C+5+CMD_GAP.
- Arbitration priority is fetch over programming, with one exception. If pg_req is pending and the fetch-streak counter equals FETCH_BURST_MAX, programming wins.
- Starvation counter:
  - increments on each fetch grant made while pg_req=1
  - clears on any pg grant, or when pg_req=0 in IDLE
  - saturates at FETCH_BURST_MAX
- Simultaneous if_req and pg_req with counter < FETCH_BURST_MAX: fetch wins.
- if_rdata and pg_rdata are independent registers. Each holds until its own next ack.
- Erase-all clears the whole array. Software must erase before rewriting any nonzero word; otherwise f_error is returned as pg_err=1.

Decomposition:
- flash_ctrl_pkg holds: op codes (OP_READ, OP_WRITE, OP_ERASE, OP_RSVD), the state encoding (IDLE, ISSUE, WAIT, DONE, GAP), and the winner-id constants (WIN_IF, WIN_PG).
- One sub-module, flash_ctrl_arb, holds the fixed-priority grant and the saturating starvation counter. Its inputs are both reqs and an IDLE strobe; its output is the one-hot grant.
- Sequencing, checks and latches stay in flash_ctrl.

Test Plan:
- Flash preloaded with word 5 = 0xDEADBEEF; if_req with if_addr=5 -> f_rd_en high exactly one cycle, if_ack 3 cycles after IDLE sample, if_rdata=0xDEADBEEF, if_err=0.
- pg erase, then pg write of 0x12345678 to addr 7, then pg read of addr 7 -> pg_err=0 three times, pg_rdata=0x12345678. A second write to addr 7 -> pg_err=1 (from f_error).
- if_req held high continuously and pg_req raised with FETCH_BURST_MAX=4 -> exactly 4 fetch acks, then pg_ack, then fetch resumes.
- pg write with wp=1, pg write to addr 1024, pg_op=11 -> each gives pg_ack one cycle after IDLE with pg_err=1 and no strobe. With PROT_LIMIT=16, a write to addr 3 -> err=1 while a write to addr 16 succeeds.
- RST asserted during ISSUE of a write -> strobes go low asynchronously, no pg_ack, ctrl_busy=0. After release, a new read completes normally.
- CMD_GAP=3 with back-to-back fetches -> strobe-to-strobe spacing is 7 cycles; with CMD_GAP=0 the spacing is 4 cycles.
